// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
//   fetch_state_e      - sequencer FSM state (IDLE, FETCH, HALTED)
//   HALT_INSTR_DEFAULT - default encoding of the instruction that stops fetching
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_out_stage.sv
// fetch_out_stage: valid/ready output register between the fetch logic and decode.
//   clk, reset       - clock, asynchronous active-high reset
//   load_i           - capture data_i/pc_i and raise valid
//   flush_i          - drop valid (wins over load_i); payload is left as is
//   ready_i          - consumer accepts the held instruction this cycle
//   data_i, pc_i     - instruction word and its address to capture
//   valid_o, data_o, pc_o - registered output to the decode stage
module fetch_out_stage #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic          flush_i,
    input  logic          ready_i,
    input  logic [DW-1:0] data_i,
    input  logic [AW-1:0] pc_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [AW-1:0] pc_o
);

    logic          valid_q;
    logic [DW-1:0] data_q;
    logic [AW-1:0] pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            pc_q    <= pc_i;
        end else if (valid_q && ready_i) begin
            // accepted and nothing new behind it
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, drives the combinational instruction memory and
// hands fetched words to decode through a valid/ready register.
//   clk, reset            - clock, asynchronous active-high reset
//   start                 - pulse in IDLE begins fetching on the next edge
//   imem_addr/imem_instr  - word address out, combinational read data in
//   instr_valid/ready/out/pc - decoded-side handshake and payload
//   redirect_valid/pc     - branch/jump target; flushes the pending word
//   halted                - HALTED state indicator
//   fault                 - sticky out-of-range fetch flag (cleared by redirect)
//   fetch_count           - saturating count of completed handshakes
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH  = 32,
    parameter int unsigned             INSTR_WIDTH = 32,
    parameter int unsigned             MEM_DEPTH   = 65536,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0]  HALT_INSTR  = INSTR_WIDTH'(HALT_INSTR_DEFAULT),
    parameter int unsigned             CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   halted,
    output logic                   fault,
    output logic [CNT_WIDTH-1:0]   fetch_count
);

    // one extra bit so a depth of 2^ADDR_WIDTH never faults
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(MEM_DEPTH);

    fetch_state_e          state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  fault_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic can_load, handshake, pc_oor, is_halt;
    logic out_load, out_flush;

    assign handshake = instr_valid && instr_ready;
    assign can_load  = !instr_valid || instr_ready;
    assign pc_oor    = {1'b0, pc_q} >= DEPTH_L;
    assign is_halt   = (imem_instr == HALT_INSTR);

    // output-register control; redirect beats capture, a fault drops valid
    always_comb begin
        out_load  = 1'b0;
        out_flush = 1'b0;
        case (state_q)
            FETCH: begin
                if (redirect_valid) out_flush = 1'b1;
                else if (can_load) begin
                    if (pc_oor) out_flush = 1'b1;
                    else        out_load  = 1'b1;
                end
            end
            HALTED:  out_flush = redirect_valid;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (handshake && (cnt_q != '1)) cnt_q <= cnt_q + CNT_WIDTH'(1);
            case (state_q)
                IDLE: begin
                    if (redirect_valid) pc_q    <= redirect_pc;
                    if (start)          state_q <= FETCH;
                end
                FETCH: begin
                    if (redirect_valid) pc_q <= redirect_pc;
                    else if (can_load) begin
                        if (pc_oor) begin
                            fault_q <= 1'b1;
                            state_q <= HALTED;
                        end else if (is_halt) begin
                            state_q <= HALTED;  // pc parks on the halt word
                        end else begin
                            pc_q <= pc_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                HALTED: begin
                    if (redirect_valid) begin
                        pc_q    <= redirect_pc;
                        fault_q <= 1'b0;
                        state_q <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fetch_out_stage #(.DW(INSTR_WIDTH), .AW(ADDR_WIDTH)) u_out (
        .clk     (clk),
        .reset   (reset),
        .load_i  (out_load),
        .flush_i (out_flush),
        .ready_i (instr_ready),
        .data_i  (imem_instr),
        .pc_i    (pc_q),
        .valid_o (instr_valid),
        .data_o  (instr_out),
        .pc_o    (instr_pc)
    );

    assign imem_addr   = pc_q;
    assign halted      = (state_q == HALTED);
    assign fault       = fault_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench: two sequencers share stimulus and a 32-word memory image. Instance A
// uses default depth/counter width, instance B has MEM_DEPTH=4, CNT_WIDTH=2.
// A per-cycle reference model checks both every cycle; directed literals pin it.
module tb_fetch_sequencer;

    localparam int MI = 0, MF = 1, MH = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, rdy = 1'b1, redir = 1'b0;
    logic [31:0] rpc = '0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:31];

    logic [31:0] addr_a, ia, out_a, opc_a, addr_b, ib, out_b, opc_b;
    logic        v_a, h_a, f_a, v_b, h_b, f_b;
    logic [31:0] cnt_a;
    logic [1:0]  cnt_b;

    assign ia = (addr_a < 32) ? mem[addr_a[4:0]] : 32'hDEAD_BEEF;
    assign ib = (addr_b < 32) ? mem[addr_b[4:0]] : 32'hDEAD_BEEF;

    fetch_sequencer dut_a (
        .clk(clk), .reset(reset), .start(start), .imem_addr(addr_a), .imem_instr(ia),
        .instr_valid(v_a), .instr_ready(rdy), .instr_out(out_a), .instr_pc(opc_a),
        .redirect_valid(redir), .redirect_pc(rpc), .halted(h_a), .fault(f_a),
        .fetch_count(cnt_a));

    fetch_sequencer #(.MEM_DEPTH(4), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .imem_addr(addr_b), .imem_instr(ib),
        .instr_valid(v_b), .instr_ready(rdy), .instr_out(out_b), .instr_pc(opc_b),
        .redirect_valid(redir), .redirect_pc(rpc), .halted(h_b), .fault(f_b),
        .fetch_count(cnt_b));

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint unsigned dep  [2] = '{65536, 4};
    longint unsigned cmax [2] = '{64'hFFFF_FFFF, 3};
    int              m_st [2] = '{MI, MI};
    logic [31:0]     m_pc [2] = '{0, 0};
    logic [31:0]     m_out[2] = '{0, 0};
    logic [31:0]     m_opc[2] = '{0, 0};
    logic            m_v  [2] = '{0, 0};
    logic            m_f  [2] = '{0, 0};
    longint unsigned m_cnt[2] = '{0, 0};

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a < 32) ? mem[a[4:0]] : 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_st[k] <= MI; m_pc[k] <= 32'd0; m_out[k] <= 32'd0; m_opc[k] <= 32'd0;
                m_v[k] <= 1'b0; m_f[k] <= 1'b0; m_cnt[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_v[k] && rdy && m_cnt[k] < cmax[k]) m_cnt[k] <= m_cnt[k] + 1;
                if (m_st[k] == MI) begin
                    if (redir) m_pc[k] <= rpc;
                    if (start) m_st[k] <= MF;
                    if (m_v[k] && rdy) m_v[k] <= 1'b0;
                end else if (m_st[k] == MF) begin
                    if (redir) begin
                        m_pc[k] <= rpc; m_v[k] <= 1'b0;
                    end else if (!m_v[k] || rdy) begin
                        if (longint'(m_pc[k]) >= dep[k]) begin
                            m_f[k] <= 1'b1; m_v[k] <= 1'b0; m_st[k] <= MH;
                        end else begin
                            m_out[k] <= mem_rd(m_pc[k]); m_opc[k] <= m_pc[k]; m_v[k] <= 1'b1;
                            if (mem_rd(m_pc[k]) == 32'hFFFF_FFFF) m_st[k] <= MH;
                            else m_pc[k] <= m_pc[k] + 32'd1;
                        end
                    end
                end else begin
                    if (redir) begin
                        m_pc[k] <= rpc; m_f[k] <= 1'b0; m_v[k] <= 1'b0; m_st[k] <= MF;
                    end else if (m_v[k] && rdy) m_v[k] <= 1'b0;
                end
            end
        end
    end

    task automatic cmp_inst(input int k, input string p, input logic v, input logic [31:0] o,
                            input logic [31:0] pc, input logic h, input logic f,
                            input logic [63:0] c, input logic [31:0] a);
        chk({p, " valid"},  64'(v), 64'(m_v[k]));
        chk({p, " halted"}, 64'(h), 64'(m_st[k] == MH));
        chk({p, " fault"},  64'(f), 64'(m_f[k]));
        chk({p, " count"},  c, m_cnt[k]);
        chk({p, " addr"},   64'(a), 64'(m_pc[k]));
        if (m_v[k]) begin
            chk({p, " out"}, 64'(o),  64'(m_out[k]));
            chk({p, " pc"},  64'(pc), 64'(m_opc[k]));
        end
    endtask

    always @(negedge clk) begin
        cmp_inst(0, "A", v_a, out_a, opc_a, h_a, f_a, 64'(cnt_a), addr_a);
        cmp_inst(1, "B", v_b, out_b, opc_b, h_b, f_b, 64'(cnt_b), addr_b);
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic boot();
        reset = 1'b1; cyc(1);
        reset = 1'b0; start = 1'b1; cyc(1);   // start edge: no fetch yet
        start = 1'b0;
    endtask

    logic [31:0] exp1 [4] = '{32'h11, 32'h22, 32'h33, 32'hFFFF_FFFF};

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h100 + i;
        for (int i = 0; i < 4; i++)  mem[i] = exp1[i];
        cyc(2);
        @(negedge clk); #1;
        chk("rst valid", 64'(v_a), 64'd0);
        chk("rst count", 64'(cnt_a), 64'd0);
        chk("rst addr", 64'(addr_a), 64'd0);
        chk("rst halted", 64'(h_a), 64'd0);

        // 1: straight run to HALT
        boot();
        @(negedge clk);
        chk("t1 no fetch at start", 64'(v_a), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1 valid", 64'(v_a), 64'd1);
            chk("t1 out", 64'(out_a), 64'(exp1[i]));
            chk("t1 pc", 64'(opc_a), 64'(i));
        end
        chk("t1 halted", 64'(h_a), 64'd1);
        @(negedge clk);
        chk("t1 count", 64'(cnt_a), 64'd4);
        chk("t1 parked pc", 64'(addr_a), 64'd3);
        chk("t1 valid drop", 64'(v_a), 64'd0);

        // 2: 3-cycle stall on first word
        cyc(1);
        boot();
        cyc(1);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1); @(negedge clk);
            chk("t2 hold out", 64'(out_a), 64'h11);
            chk("t2 hold pc", 64'(opc_a), 64'd0);
            chk("t2 hold addr", 64'(addr_a), 64'd1);
        end
        rdy = 1'b1;
        cyc(8);
        chk("t2 count", 64'(cnt_a), 64'd4);
        chk("t2 halted", 64'(h_a), 64'd1);

        // 3: redirect while 0x22 pending
        boot();
        cyc(2);
        rdy = 1'b0; redir = 1'b1; rpc = 32'h10;
        @(negedge clk);
        chk("t3 pending", 64'(out_a), 64'h22);
        cyc(1);
        redir = 1'b0; rdy = 1'b1;
        @(negedge clk);
        chk("t3 flushed", 64'(v_a), 64'd0);
        chk("t3 addr", 64'(addr_a), 64'h10);
        cyc(1); @(negedge clk);
        chk("t3 target out", 64'(out_a), 64'h110);
        chk("t3 target pc", 64'(opc_a), 64'h10);

        // 4 + 6: out-of-range fault on B, redirect clears it, counter saturates
        reset = 1'b1; cyc(1);
        for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + i;
        reset = 1'b0; start = 1'b1; cyc(1);
        start = 1'b0;
        cyc(5); @(negedge clk);
        chk("t4 fault", 64'(f_b), 64'd1);
        chk("t4 halted", 64'(h_b), 64'd1);
        chk("t4 valid", 64'(v_b), 64'd0);
        chk("t6 sat count", 64'(cnt_b), 64'd3);
        redir = 1'b1; rpc = 32'd0;
        cyc(1);
        redir = 1'b0;
        @(negedge clk);
        chk("t4 fault clr", 64'(f_b), 64'd0);
        cyc(1); @(negedge clk);
        chk("t4 refetch", 64'(out_b), 64'hA0);
        chk("t4 refetch pc", 64'(opc_b), 64'd0);
        cyc(4);
        chk("t6 still sat", 64'(cnt_b), 64'd3);

        // 5: async reset mid-fetch (A streaming, B faulted)
        reset = 1'b1; #1;
        chk("t5 valid", 64'(v_a), 64'd0);
        chk("t5 count", 64'(cnt_a), 64'd0);
        chk("t5 fault", 64'(f_b), 64'd0);
        chk("t5 pc", 64'(addr_a), 64'd0);
        chk("t5 halted", 64'(h_b), 64'd0);
        cyc(1);
        reset = 1'b0;
        cyc(4); @(negedge clk);
        chk("t5 idle valid", 64'(v_a), 64'd0);
        chk("t5 idle addr", 64'(addr_a), 64'd0);
        chk("t5 idle count", 64'(cnt_b), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that owns the PC and sequences the combinational instructionMemory.
- Drives the word address, captures the returned instruction into a valid/ready output register, and handles start, stall, redirect and halt.
- Sits between instructionMemory and the decode stage of the NN simulator core.

Parameters:
ADDR_WIDTH, 32, width of PC / memory word address
INSTR_WIDTH, 32, instruction word width
MEM_DEPTH, 65536, number of valid memory words; addresses >= MEM_DEPTH fault
RESET_PC, 0, PC value loaded at reset
HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetching
CNT_WIDTH, 32, width of fetch_count

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins fetching from IDLE
imem_addr  out  ADDR_WIDTH  word address to instructionMemory (equals pc register)
imem_instr  in  INSTR_WIDTH  combinational read data from instructionMemory
instr_valid  out  1  instr_out/instr_pc hold a valid instruction
instr_ready  in  1  consumer accepts the instruction this cycle
instr_out  out  INSTR_WIDTH  fetched instruction
instr_pc  out  ADDR_WIDTH  address of instr_out
redirect_valid  in  1  branch/jump redirect request
redirect_pc  in  ADDR_WIDTH  redirect target
halted  out  1  high in HALTED state
fault  out  1  sticky out-of-range fetch flag
fetch_count  out  CNT_WIDTH  number of completed handshakes

Behaviour:
- Reset (async, any state): state=IDLE, pc=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0, fault=0, fetch_count=0. halted=0 via state.
- imem_addr = pc, combinational. No other logic on the memory path.
- Handshake: a transfer occurs when instr_valid && instr_ready. While instr_valid && !instr_ready, instr_out, instr_pc and pc hold stable.
- can_load = !instr_valid || instr_ready.
- IDLE:
  - start -> FETCH on the next edge. No fetch occurs in the start cycle.
  - redirect_valid loads pc <= redirect_pc and stays in IDLE.
- FETCH, redirect_valid=1 (highest priority):
  - pc <= redirect_pc, instr_valid <= 0 (flush).
  - No memory capture that cycle.
  - A handshake in the same cycle still counts.
- FETCH, can_load && pc >= MEM_DEPTH:
  - fault <= 1, instr_valid <= 0, state <= HALTED.
- FETCH, can_load, in range:
  - instr_out <= imem_instr, instr_pc <= pc, instr_valid <= 1.
  - If imem_instr == HALT_INSTR: pc holds, state <= HALTED. The halt word is still delivered.
  - Else pc <= pc + 1, wrapping modulo 2^ADDR_WIDTH.
- Latency:
  - Instruction at address A is on instr_out one cycle after the cycle where pc==A and can_load.
  - Sustained throughput is 1 instruction/cycle with instr_ready=1.
- HALTED:
  - No fetches. A pending instr_valid stays until accepted, then drops.
  - redirect_valid: pc <= redirect_pc, fault <= 0, instr_valid <= 0, state <= FETCH.
  - start is ignored.
- start is ignored outside IDLE.
- fetch_count:
  - +1 on every handshake, in every state; saturates at all-ones.
  - Cleared only by reset.

Decomposition:
- Package fetch_pkg holds the state enum (IDLE, FETCH, HALTED) and the HALT_INSTR default constant.
- One natural sub-module: fetch_out_stage, the valid/ready output register with flush input. The parent holds the PC, FSM and counter.

Test Plan:
1. Memory [0]=0x11, [1]=0x22, [2]=0x33, [3]=HALT; reset, start pulse, instr_ready=1 -> instr_out sequence 0x11@pc0, 0x22@pc1, 0x33@pc2, HALT@pc3 on consecutive cycles; halted=1 after HALT captured; fetch_count=4; pc=3.
2. Same image, instr_ready low for 3 cycles after first valid -> instr_out=0x11, instr_pc=0 held stable; imem_addr stays 1; fetch resumes without loss or duplication.
3. Mid-stream redirect_valid with redirect_pc=0x10 while 0x22 pending -> instr_valid drops the next cycle; the next delivered instruction is mem[0x10] with instr_pc=0x10.
4. MEM_DEPTH=4, memory without HALT -> four instructions delivered, then fault=1 and halted=1; a later redirect to 0 clears fault and refetches mem[0].
5. Assert reset mid-fetch with instr_valid=1 -> instr_valid, fault, fetch_count become 0 immediately; pc=RESET_PC; state IDLE; nothing is fetched until start.
6. Counter saturation with CNT_WIDTH=2 -> after 5 handshakes fetch_count=3.
